// File: rtl/weight_fifo_pkg.sv
// Shared types and sizing for the weight FIFO bank controllers (write and read side).
package weight_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } wf_state_e;

    localparam int unsigned DEF_SYS_ROW    = 16;
    localparam int unsigned DEF_FIFO_WIDTH = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 16;

    // Occupancy/credit counters must hold the value FIFO_DEPTH itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

endpackage

// File: rtl/weight_fifo_in_ctrl_rd_latency_pipe.sv
// Valid shift register matching the weight-buffer read latency; synchronous clear drops in-flight reads.
module rd_latency_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_vld,
    output logic o_vld
);

    logic [DEPTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (i_clr) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= i_vld;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (i_clr) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[DEPTH-2:0], i_vld};
                end
            end
        end
    endgenerate

    assign o_vld = r_pipe[DEPTH-1];

endmodule

// File: rtl/weight_fifo_in_ctrl.sv
// Write-side controller of the weight FIFO bank: streams tile rows from the weight buffer
// into the column FIFOs under a credit limit and reports per-tile completion.
module weight_fifo_in_ctrl
    import weight_fifo_pkg::*;
#(
    parameter  int unsigned SYS_ROW    = DEF_SYS_ROW,
    parameter  int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int unsigned RD_LATENCY = 2,
    parameter  int unsigned ADDR_W     = 12,
    parameter  int unsigned TILE_W     = 8,
    localparam int unsigned CNT_W      = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [TILE_W-1:0]     i_num_tiles,
    input  logic                  i_fifo_pop,
    output logic                  o_buf_rd_en,
    output logic [ADDR_W-1:0]     o_buf_rd_addr,
    output logic [FIFO_WIDTH-1:0] o_fifo_wr_en,
    output logic [CNT_W-1:0]      o_occupancy,
    output logic                  o_tile_loaded,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pop_err
);

    localparam int unsigned ROW_W = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1;
    localparam int unsigned CW1   = CNT_W + 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SYS_ROW - 1);
    localparam logic [CW1-1:0]   DEPTH_C  = CW1'(FIFO_DEPTH);

    wf_state_e         r_state;
    wf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [TILE_W-1:0] r_num_tiles;
    logic [ROW_W-1:0]  r_issue_row;
    logic [TILE_W-1:0] r_issue_tile;
    logic [ROW_W-1:0]  r_wr_row;
    logic [CNT_W-1:0]  r_inflight;
    logic [CNT_W-1:0]  r_occ;
    logic              r_pop_err;
    logic [CW1-1:0]    w_credit;
    logic              w_rd_en;
    logic              w_wr;
    logic              w_done;
    logic              w_pop_ok;
    logic              w_start_ok;

    // Credit uses registered counts only, so a same-cycle pop frees its slot one cycle later.
    assign w_credit   = {1'b0, r_occ} + {1'b0, r_inflight};
    assign w_pop_ok   = i_fifo_pop && (r_occ != '0);
    assign w_start_ok = (r_state == IDLE) && i_start;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_num_tiles == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                w_rd_en = (w_credit < DEPTH_C);
                if (w_rd_en && (r_issue_row == ROW_LAST) &&
                    (r_issue_tile == r_num_tiles - TILE_W'(1))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_inflight == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read address and issue-side row/tile position.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_addr    <= '0;
            r_num_tiles  <= '0;
            r_issue_row  <= '0;
            r_issue_tile <= '0;
        end else if (w_start_ok) begin
            r_rd_addr    <= i_base_addr;
            r_num_tiles  <= i_num_tiles;
            r_issue_row  <= '0;
            r_issue_tile <= '0;
        end else if (w_rd_en) begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
            if (r_issue_row == ROW_LAST) begin
                r_issue_row  <= '0;
                r_issue_tile <= r_issue_tile + TILE_W'(1);
            end else begin
                r_issue_row <= r_issue_row + ROW_W'(1);
            end
        end
    end

    rd_latency_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_lat_pipe (
        .clk   (clk),
        .i_clr (!rstn),
        .i_vld (w_rd_en),
        .o_vld (w_wr)
    );

    // Write-side bookkeeping: in-flight reads, FIFO occupancy, tile row count, pop error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_inflight <= '0;
            r_occ      <= '0;
            r_wr_row   <= '0;
            r_pop_err  <= 1'b0;
        end else begin
            if (w_rd_en && !w_wr) begin
                r_inflight <= r_inflight + CNT_W'(1);
            end else if (!w_rd_en && w_wr) begin
                r_inflight <= r_inflight - CNT_W'(1);
            end
            if (w_wr && !w_pop_ok) begin
                r_occ <= r_occ + CNT_W'(1);
            end else if (!w_wr && w_pop_ok) begin
                r_occ <= r_occ - CNT_W'(1);
            end
            if (w_wr) begin
                r_wr_row <= (r_wr_row == ROW_LAST) ? '0 : r_wr_row + ROW_W'(1);
            end
            if (i_fifo_pop && (r_occ == '0)) begin
                r_pop_err <= 1'b1;
            end
        end
    end

    assign o_buf_rd_en   = w_rd_en;
    assign o_buf_rd_addr = r_rd_addr;
    assign o_fifo_wr_en  = {FIFO_WIDTH{w_wr}};
    assign o_occupancy   = r_occ;
    assign o_tile_loaded = w_wr && (r_wr_row == ROW_LAST);
    assign o_busy        = (r_state != IDLE);
    assign o_done        = w_done;
    assign o_pop_err     = r_pop_err;

endmodule

// File: tb/tb_weight_fifo_in_ctrl.sv
// Scoreboard bench for weight_fifo_in_ctrl: directed scenarios queue expected events by cycle.
module tb_weight_fifo_in_ctrl;
    import weight_fifo_pkg::*;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned TILE_W = 8;
    localparam int unsigned FW     = DEF_FIFO_WIDTH;
    localparam int unsigned CNT_W  = cnt_width(DEF_FIFO_DEPTH);

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [TILE_W-1:0] ntiles;
    logic              pop;
    logic              o_buf_rd_en;
    logic [ADDR_W-1:0] o_buf_rd_addr;
    logic [FW-1:0]     o_fifo_wr_en;
    logic [CNT_W-1:0]  o_occupancy;
    logic              o_tile_loaded;
    logic              o_busy;
    logic              o_done;
    logic              o_pop_err;

    weight_fifo_in_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_start       (start),
        .i_base_addr   (base),
        .i_num_tiles   (ntiles),
        .i_fifo_pop    (pop),
        .o_buf_rd_en   (o_buf_rd_en),
        .o_buf_rd_addr (o_buf_rd_addr),
        .o_fifo_wr_en  (o_fifo_wr_en),
        .o_occupancy   (o_occupancy),
        .o_tile_loaded (o_tile_loaded),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_pop_err     (o_pop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; } rd_t;
    typedef struct { int cyc; int occ; int perr; int busy; } st_t;

    rd_t rd_q[$];
    int  wr_q[$];
    int  tl_q[$];
    int  done_q[$];
    st_t st_q[$];

    int checks = 0;
    int errors = 0;
    int flush_cnt = 0;
    int flush_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        rd_t r;
        st_t s;
        int  c;
        if (o_buf_rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                r = rd_q.pop_front();
                chk("rd_cycle", cyc, r.cyc);
                chk("rd_addr", int'(o_buf_rd_addr), r.addr);
            end
        end
        if (o_fifo_wr_en != '0) begin
            chk("wr_mask", int'(o_fifo_wr_en), 32'hFFFF);
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                c = wr_q.pop_front();
                chk("wr_cycle", cyc, c);
            end
        end
        if (o_tile_loaded) begin
            if (tl_q.size() == 0) chk("tile_unexpected", 1, 0);
            else begin
                c = tl_q.pop_front();
                chk("tile_cycle", cyc, c);
            end
        end
        if (o_done) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                c = done_q.pop_front();
                chk("done_cycle", cyc, c);
            end
        end
        if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            s = st_q.pop_front();
            chk("occupancy", int'(o_occupancy), s.occ);
            chk("pop_err", int'(o_pop_err), s.perr);
            chk("busy", int'(o_busy), s.busy);
        end
        if (flush_cnt != flush_seen) begin
            flush_seen = flush_cnt;
            chk("rd_left", rd_q.size(), 0);
            chk("wr_left", wr_q.size(), 0);
            chk("tile_left", tl_q.size(), 0);
            chk("done_left", done_q.size(), 0);
            chk("state_left", st_q.size(), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic flush();
        flush_cnt++;
        step();
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; pop = 1'b0; base = '0; ntiles = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic exp_reads(input int c0, input int a0, input int n);
        rd_t r;
        for (int k = 0; k < n; k++) begin
            r.cyc  = c0 + k;
            r.addr = (a0 + k) % 4096;
            rd_q.push_back(r);
        end
    endtask

    task automatic exp_writes(input int c0, input int n);
        for (int k = 0; k < n; k++) wr_q.push_back(c0 + k);
    endtask

    task automatic exp_st(input int c, input int occ, input int perr, input int busy);
        st_t s;
        s.cyc = c; s.occ = occ; s.perr = perr; s.busy = busy;
        st_q.push_back(s);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [TILE_W-1:0] n);
        start = 1'b1; base = b; ntiles = n;
        step();
        start = 1'b0;
    endtask

    // One tile from base 0x010, no pops.
    task automatic run_single();
        int t0;
        t0 = cyc;
        exp_st(t0, 0, 0, 0);
        exp_reads(t0 + 1, 'h010, 16);
        exp_writes(t0 + 3, 16);
        tl_q.push_back(t0 + 18);
        done_q.push_back(t0 + 19);
        exp_st(t0 + 19, 16, 0, 1);
        exp_st(t0 + 20, 16, 0, 0);
        pulse_start(12'h010, 8'd1);
        wait_until(t0 + 24);
        flush();
    endtask

    initial begin
        int t0;
        do_reset();

        run_single();

        // Reset during ISSUE drops pending writes; a fresh start behaves as before.
        do_reset();
        t0 = cyc;
        exp_reads(t0 + 1, 'h010, 8);
        exp_writes(t0 + 3, 6);
        exp_st(t0 + 8, 5, 0, 1);
        exp_st(t0 + 9, 0, 0, 0);
        exp_st(t0 + 10, 0, 0, 0);
        pulse_start(12'h010, 8'd1);
        wait_until(t0 + 8);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        wait_until(t0 + 14);
        flush();
        run_single();

        // Write and pop together at occupancy 5; start while busy is ignored.
        do_reset();
        t0 = cyc;
        exp_reads(t0 + 1, 'h123, 16);
        exp_writes(t0 + 3, 16);
        tl_q.push_back(t0 + 18);
        done_q.push_back(t0 + 19);
        exp_st(t0 + 8, 5, 0, 1);
        exp_st(t0 + 9, 5, 0, 1);
        exp_st(t0 + 10, 6, 0, 1);
        exp_st(t0 + 20, 15, 0, 0);
        pulse_start(12'h123, 8'd1);
        wait_until(t0 + 5);
        pulse_start(12'h7AA, 8'd3);
        wait_until(t0 + 8);
        pop = 1'b1;
        step();
        pop = 1'b0;
        wait_until(t0 + 24);
        flush();

        // Backpressure with address wrap: FIFOs fill, one pop releases one read.
        do_reset();
        t0 = cyc;
        exp_reads(t0 + 1, 'hFF8, 16);
        exp_reads(t0 + 31, 'h008, 1);
        exp_writes(t0 + 3, 16);
        exp_writes(t0 + 33, 1);
        tl_q.push_back(t0 + 18);
        exp_st(t0 + 20, 16, 0, 1);
        exp_st(t0 + 30, 16, 0, 1);
        exp_st(t0 + 31, 15, 0, 1);
        exp_st(t0 + 33, 15, 0, 1);
        exp_st(t0 + 34, 16, 0, 1);
        pulse_start(12'hFF8, 8'd2);
        wait_until(t0 + 30);
        pop = 1'b1;
        step();
        pop = 1'b0;
        wait_until(t0 + 40);
        flush();

        // Two tiles streamed with continuous pops.
        do_reset();
        t0 = cyc;
        exp_reads(t0 + 1, 'hFF0, 32);
        exp_writes(t0 + 3, 32);
        tl_q.push_back(t0 + 18);
        tl_q.push_back(t0 + 34);
        done_q.push_back(t0 + 35);
        exp_st(t0 + 10, 1, 0, 1);
        exp_st(t0 + 35, 1, 0, 1);
        exp_st(t0 + 36, 0, 0, 0);
        pulse_start(12'hFF0, 8'd2);
        wait_until(t0 + 4);
        pop = 1'b1;
        wait_until(t0 + 36);
        pop = 1'b0;
        wait_until(t0 + 40);
        flush();

        // Pop on empty FIFO sets a sticky error; num_tiles=0 completes with no reads.
        t0 = cyc;
        exp_st(t0, 0, 0, 0);
        exp_st(t0 + 1, 0, 1, 0);
        exp_st(t0 + 4, 0, 1, 0);
        pop = 1'b1;
        step();
        pop = 1'b0;
        wait_until(t0 + 5);
        t0 = cyc;
        done_q.push_back(t0 + 1);
        exp_st(t0 + 1, 0, 1, 1);
        exp_st(t0 + 2, 0, 1, 0);
        pulse_start(12'h055, 8'd0);
        wait_until(t0 + 5);
        flush();

        do_reset();
        exp_st(cyc, 0, 0, 0);
        step();
        flush();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
